// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM encoding
// and default busy-period lengths.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // Busy periods up to 65536 cycles are representable.
    localparam int MDU_CNT_W = 16;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit signed/unsigned divider. Quotient truncates toward
// zero and the remainder follows the sign of the dividend.
module mdu_divider (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] safe_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        neg_q;
    logic        neg_r;
    logic        overflow;

    assign div_zero = (divisor == 32'd0);
    assign overflow = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

    assign abs_a  = (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
    assign abs_b  = (is_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;
    // Substitute 1 for a zero divisor so the result is defined; the caller discards it.
    assign safe_b = div_zero ? 32'd1 : abs_b;
    assign uq     = abs_a / safe_b;
    assign ur     = abs_a % safe_b;
    assign neg_q  = is_signed && (dividend[31] ^ divisor[31]);
    assign neg_r  = is_signed && dividend[31];

    always_comb begin
        quotient  = neg_q ? (32'd0 - uq) : uq;
        remainder = neg_r ? (32'd0 - ur) : ur;
        if (overflow) begin
            quotient  = 32'h8000_0000;
            remainder = 32'd0;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute
// stage. The result is computed at start and committed after the busy period.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Handshake: start is a single-cycle strobe honoured only while busy is
    // low; done pulses for one cycle after a mult/div commits to HI/LO.

    localparam logic [MDU_CNT_W-1:0] MULT_LOAD = MDU_CNT_W'(MULT_CYCLES - 1);
    localparam logic [MDU_CNT_W-1:0] DIV_LOAD  = MDU_CNT_W'(DIV_CYCLES - 1);

    mdu_state_e           state_q, state_d;
    logic [MDU_CNT_W-1:0] count_q, count_d;
    logic [63:0]          pend_q, pend_d;
    logic                 skip_q, skip_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;
    logic                 done_q, done_d;

    logic signed [63:0]   prod_s;
    logic [63:0]          prod_u;
    logic [31:0]          quot;
    logic [31:0]          rem;
    logic                 div_zero;

    assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    mdu_divider u_divider (
        .dividend  (src_a),
        .divisor   (src_b),
        .is_signed (op == MDU_DIV),
        .quotient  (quot),
        .remainder (rem),
        .div_zero  (div_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MDU_IDLE;
            count_q <= '0;
            pend_q  <= '0;
            skip_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            skip_q  <= skip_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pend_d  = pend_q;
        skip_d  = skip_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT: begin
                            pend_d  = prod_s;
                            skip_d  = 1'b0;
                            count_d = MULT_LOAD;
                            state_d = MDU_RUN;
                        end
                        MDU_MULTU: begin
                            pend_d  = prod_u;
                            skip_d  = 1'b0;
                            count_d = MULT_LOAD;
                            state_d = MDU_RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            pend_d  = {rem, quot};
                            skip_d  = div_zero;
                            count_d = DIV_LOAD;
                            state_d = MDU_RUN;
                        end
                        MDU_MTHI: hi_d = src_a;
                        MDU_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            MDU_RUN: begin
                if (count_q == '0) begin
                    state_d = MDU_IDLE;
                    done_d  = 1'b1;
                    // A zero divisor runs the full period but leaves HI/LO intact.
                    if (!skip_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    assign busy = (state_q == MDU_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected HI/LO pairs
// popped on each done pulse, plus timing, hold and reset checks.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] prev_hl;
    int          n_checks;
    int          n_fail;

    mul_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int sa;
        int sb;
        sa = a;
        sb = b;
        r  = {m_hi, m_lo};
        case (o)
            MDU_MULT:  r = longint'(sa) * longint'(sb);
            MDU_MULTU: r = {32'd0, a} * {32'd0, b};
            MDU_DIV: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                    else r = {32'(sa % sb), 32'(sa / sb)};
                end
            end
            MDU_DIVU: if (b != 32'd0) r = {a % b, a / b};
            default: ;
        endcase
        return r;
    endfunction

    // Scoreboard: every done pulse pops one expected HI/LO pair.
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) check("unexpected_done", done, 1'b0);
            else check("result", {hi, lo}, exp_q.pop_front());
        end
    end

    // Drivers: called at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        prev_hl = {hi, lo};
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int n, input int inject_at);
        int cyc;
        cyc = 0;
        while (busy && cyc < 200) begin
            check("hold", {hi, lo}, prev_hl);
            check("done_low_in_run", done, 1'b0);
            if (cyc == inject_at) begin
                start = 1'b1;
                op    = MDU_DIV;
                src_a = 32'd1000;
                src_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", 64'(cyc), 64'(n));
        check("done_pulse", done, 1'b1);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int n, input int inject_at);
        exp_q.push_back(exp);
        {m_hi, m_lo} = exp;
        issue(o, a, b);
        wait_idle(n, inject_at);
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] d);
        start = 1'b1;
        op    = o;
        src_a = d;
        src_b = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        if (o == MDU_MTHI) m_hi = d;
        else m_lo = d;
        check("mt_value", {hi, lo}, {m_hi, m_lo});
        check("mt_busy", busy, 1'b0);
        @(negedge clk);
        check("mt_no_done", done, 1'b0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_fail   = 0;
        m_hi     = '0;
        m_lo     = '0;
        start    = 1'b0;
        op       = '0;
        src_a    = '0;
        src_b    = '0;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        do_op(MDU_MULT,  32'hFFFF_FFFF, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 5, -1);
        @(negedge clk);
        check("done_once", done, 1'b0);
        do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'h2, {32'h0000_0001, 32'hFFFF_FFFE}, 5, -1);
        do_op(MDU_DIV,   32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, -1);
        do_op(MDU_DIVU,  32'd7, 32'd2, {32'd1, 32'd3}, 10, -1);
        do_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10, -1);

        mt(MDU_MTHI, 32'h1234_5678);
        do_op(MDU_DIV, 32'd99, 32'd0, {32'h1234_5678, m_lo}, 10, -1);

        // Start during RUN must be ignored; the mult still commits after 5 cycles.
        do_op(MDU_MULT, 32'd3, 32'hFFFF_FFFC, {32'hFFFF_FFFF, 32'hFFFF_FFF4}, 5, 2);
        @(negedge clk);
        check("ignored_start_idle", busy, 1'b0);

        // Back-to-back: second mult issued in the cycle busy drops.
        do_op(MDU_MULTU, 32'd6, 32'd7, {32'd0, 32'd42}, 5, -1);
        do_op(MDU_MULT, 32'h0001_0000, 32'h0001_0000, {32'd1, 32'd0}, 5, -1);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom();
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom();
            do_op(ro, ra, rb, model(ro, ra, rb),
                  (ro == MDU_MULT || ro == MDU_MULTU) ? 5 : 10, -1);
        end

        // Reserved op code is ignored.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd6;
        src_a = 32'hAAAA_AAAA;
        @(negedge clk);
        start = 1'b0;
        check("reserved_busy", busy, 1'b0);
        check("reserved_hilo", {hi, lo}, {m_hi, m_lo});
        @(negedge clk);
        check("reserved_done", done, 1'b0);

        // Asynchronous reset in the middle of a divide.
        mt(MDU_MTHI, 32'h5555_5555);
        mt(MDU_MTLO, 32'h5555_5555);
        issue(MDU_DIV, 32'd1000, 32'd7);
        check("abort_pre_busy", busy, 1'b1);
        repeat (3) @(negedge clk);
        check("abort_hold", {hi, lo}, {32'h5555_5555, 32'h5555_5555});
        #2 reset = 1'b0;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("post_abort_busy", busy, 1'b0);
        end
        check("post_abort_hilo", {hi, lo}, 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multiply/divide responder for the pipelined MIPS core's execute stage. The pipeline raises `start` for one cycle with an operation code and two operands. The unit holds `busy` for a fixed, op-dependent number of cycles, then commits the 64-bit result to its HI/LO registers. The hazard logic uses `busy` to stall any following multiply/divide or HI/LO instruction in decode.

## Interface
Parameters:
- `MULT_CYCLES`, default 5, number of busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10, number of busy cycles for div/divu (≥1).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately.
- `start`  in  1  one-cycle request strobe from the execute stage.
- `op`  in  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 reserved.
- `src_a`  in  32  rs operand (dividend / multiplicand / mthi-mtlo data).
- `src_b`  in  32  rt operand (divisor / multiplier).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse in the first cycle after a mult/div commits.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Two states:
  - IDLE: `busy=0`.
  - RUN: `busy=1`, with a down-counter loaded with N−1, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- IDLE + `start` + op 0–3:
  - latch the computed 64-bit result into a pending register;
  - load the counter;
  - go to RUN.
- IDLE + `start` + op 4/5: write `src_a` to HI/LO at that edge; no busy, no `done`.
- Reserved ops are ignored.
- RUN: the counter decrements each cycle. At the edge where it is 0:
  - HI/LO ← pending;
  - return to IDLE;
  - `done` is high for the following cycle.
- `start` while in RUN is ignored entirely. The hazard logic guarantees this never occurs; the bench still checks that HI/LO and the counter are unaffected.
- mult: signed 32×32→64. multu: unsigned. HI = bits 63:32, LO = bits 31:0.
- div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Divisor 0: the full busy period still runs, but HI/LO are left unchanged at commit and `done` still pulses.
- Reset: state, counter and pending are cleared; `hi=lo=0`, `busy=0`, `done=0`.
  - Reset asserted mid-operation aborts it; nothing is committed.

## Timing
- `start` is sampled at edge T.
- `busy`:
  - high in cycles T+1 … T+N;
  - low from T+N+1.
- HI/LO:
  - show the new result from cycle T+N+1;
  - retain the previous values throughout RUN.
- `done` is high only in cycle T+N+1.
- A new `start` is accepted at edge T+N+1 (back-to-back operations are allowed).
- mthi/mtlo at edge T are visible at T+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `mdu_pkg`:
  - op-code localparams `MDU_MULT`…`MDU_MTLO`;
  - state encoding (`MDU_IDLE`, `MDU_RUN`);
  - default cycle counts.
- Sub-module `mdu_divider`: combinational signed/unsigned quotient and remainder, including the divide-by-zero flag and the overflow rule.
- The multiply is inline.

## Test plan
- mult 0xFFFFFFFF×0x00000002:
  - `busy` high for exactly 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFE;
  - one `done` pulse.
- multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div 0xFFFFFFF9 / 0x00000002:
  - 10 busy cycles;
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 7/2 → lo=3, hi=1.
- Overflow and divide-by-zero cases:
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - div by 0 after mthi 0x12345678 → hi stays 0x12345678 and lo is unchanged, with `busy` still high for 10 cycles.
- Ignored start and back-to-back operation:
  - mult started, then a second `start` (div) three cycles later → ignored; the mult result commits on schedule.
  - A new mult launched in the same cycle `busy` drops → accepted.
- Reset mid-operation:
  - a div is in flight with hi=lo=0x55555555 set via mthi/mtlo;
  - pull `reset` low asynchronously in RUN cycle 4 → hi=lo=0 and `busy`=0 immediately;
  - no `done` pulse after release.
